// File: rtl/change_dispenser.sv
// Coin payout stage: queues change amounts and pays them out one coin at a time,
// high-value coin first, handshaking each drop with the hopper sensor.
module change_dispenser #(
  parameter int AMT_W       = 6,
  parameter int COIN_HI     = 10,
  parameter int COIN_LO     = 5,
  parameter int STOCK_HI0   = 8,
  parameter int STOCK_LO0   = 8,
  parameter int PULSE_CYC   = 4,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AMT_W-1:0] change_in,
  input  logic             coin_ack,
  input  logic             refill_hi,
  input  logic             refill_lo,
  input  logic             clear_fault,
  output logic             eject_hi,
  output logic             eject_lo,
  output logic             busy,
  output logic [AMT_W-1:0] owed,
  output logic             fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_EJECT, S_WAIT_ACK, S_FAULT
  } state_e;

  localparam logic [AMT_W:0]   HI_V       = (AMT_W+1)'(COIN_HI);
  localparam logic [AMT_W:0]   LO_V       = (AMT_W+1)'(COIN_LO);
  localparam logic [AMT_W-1:0] AMT_MAX    = '1;
  localparam logic [3:0]       STK_HI0    = 4'(STOCK_HI0);
  localparam logic [3:0]       STK_LO0    = 4'(STOCK_LO0);
  localparam logic [7:0]       PULSE_LAST = 8'(PULSE_CYC - 1);
  localparam logic [7:0]       TO_LAST    = 8'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] pending_q, pending_d;
  logic [3:0]       stock_hi_q, stock_hi_d;
  logic [3:0]       stock_lo_q, stock_lo_d;
  logic             sel_hi_q, sel_hi_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             ack_ok;
  logic [AMT_W:0]   pend_ext;
  logic [AMT_W:0]   paid;
  logic [AMT_W:0]   sum;

  // Pending never drops below the coin in flight (a coin is only chosen when
  // pending covers it), so the subtraction cannot wrap; only the top needs clamping.
  always_comb begin
    ack_ok    = (state_q == S_WAIT_ACK) && coin_ack;
    pend_ext  = {1'b0, pending_q};
    paid      = ack_ok ? (sel_hi_q ? HI_V : LO_V) : '0;
    sum       = pend_ext + {1'b0, change_in} - paid;
    pending_d = sum[AMT_W] ? AMT_MAX : sum[AMT_W-1:0];
  end

  // Refill wins over a same-cycle ack: the tube is full again either way.
  always_comb begin
    stock_hi_d = stock_hi_q;
    stock_lo_d = stock_lo_q;
    if (refill_hi)                  stock_hi_d = STK_HI0;
    else if (ack_ok && sel_hi_q)    stock_hi_d = stock_hi_q - 4'd1;
    if (refill_lo)                  stock_lo_d = STK_LO0;
    else if (ack_ok && !sel_hi_q)   stock_lo_d = stock_lo_q - 4'd1;
  end

  always_comb begin
    state_d  = state_q;
    sel_hi_d = sel_hi_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pending_q != '0) state_d = S_SELECT;
      end
      S_SELECT: begin
        cnt_d = '0;
        if (pend_ext >= HI_V && stock_hi_q != '0) begin
          state_d  = S_EJECT;
          sel_hi_d = 1'b1;
        end else if (pend_ext >= LO_V && stock_lo_q != '0) begin
          state_d  = S_EJECT;
          sel_hi_d = 1'b0;
        end else if (pending_q == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_EJECT: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_WAIT_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT_ACK: begin
        // An ack on the last allowed cycle still counts as a delivered coin.
        if (coin_ack) begin
          state_d = S_SELECT;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_FAULT: begin
        if (clear_fault) state_d = S_SELECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      stock_hi_q <= STK_HI0;
      stock_lo_q <= STK_LO0;
      sel_hi_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      stock_hi_q <= stock_hi_d;
      stock_lo_q <= stock_lo_d;
      sel_hi_q   <= sel_hi_d;
      cnt_q      <= cnt_d;
    end
  end

  assign eject_hi = (state_q == S_EJECT) &&  sel_hi_q;
  assign eject_lo = (state_q == S_EJECT) && !sel_hi_q;
  assign busy     = (state_q != S_IDLE);
  assign fault    = (state_q == S_FAULT);
  assign owed     = pending_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: payout table plus hand-written corner sequences.
module tb_change_dispenser;

  localparam int AMT_W = 6;
  localparam int PULSE = 4;
  localparam int TMO   = 200;

  logic             clk = 1'b0;
  logic             rst;
  logic [AMT_W-1:0] change_in;
  logic             coin_ack, refill_hi, refill_lo, clear_fault;
  logic             eject_hi, eject_lo, busy, fault;
  logic [AMT_W-1:0] owed;

  int n_pass = 0;
  int n_tot  = 0;

  change_dispenser #(
    .AMT_W(AMT_W), .COIN_HI(10), .COIN_LO(5), .STOCK_HI0(8), .STOCK_LO0(8),
    .PULSE_CYC(PULSE), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .change_in(change_in), .coin_ack(coin_ack),
    .refill_hi(refill_hi), .refill_lo(refill_lo), .clear_fault(clear_fault),
    .eject_hi(eject_hi), .eject_lo(eject_lo), .busy(busy), .owed(owed), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    rf_hi;
    int    amt;
    string ord;
    int    owed;
    int    flt;
    int    shi;
    int    slo;
  } vec_t;

  vec_t tbl[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk_s(input string nm, input string act, input string exp);
    n_tot++;
    if (act != exp) $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst = 1'b1; change_in = '0; coin_ack = 0; refill_hi = 0; refill_lo = 0; clear_fault = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Runs the hopper model until the dispenser goes idle or faults; acks each
  // coin on the third edge after its pulse falls.
  task automatic drain(input int first_wait, output string ord, output int bad_w, output bit done);
    int  w = 0;
    bit  pe = 0;
    int  wa = first_wait;
    ord = ""; bad_w = 0; done = 0;
    for (int c = 0; c < 3000; c++) begin
      if (eject_hi | eject_lo) begin
        if (!pe) ord = {ord, eject_hi ? "H" : "L"};
        w++;
      end else if (pe) begin
        if (w != PULSE) bad_w++;
        w  = 0;
        wa = 2;
      end
      pe = eject_hi | eject_lo;
      if (wa == 0) begin coin_ack = 1'b1; wa = -1; end
      else if (wa > 0) wa--;
      if (!busy || fault) begin done = 1; break; end
      tick();
      coin_ack = 1'b0;
    end
    coin_ack = 1'b0;
  endtask

  task automatic pay(input int amt, output string ord, output int bad_w, output bit done);
    change_in = AMT_W'(amt);
    tick();
    change_in = '0;
    tick();
    drain(-1, ord, bad_w, done);
  endtask

  task automatic wait_fall(output bit saw_hi, output bit ok);
    bit seen = 0;
    saw_hi = 0; ok = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (eject_hi | eject_lo) begin seen = 1; saw_hi = eject_hi; end
      else if (seen) begin ok = 1; break; end
    end
  endtask

  initial begin
    string ord;
    int    bad_w, n;
    bit    done, saw_hi, ok;

    tbl[0] = '{rf_hi: 0, amt: 25, ord: "HHL",    owed: 0, flt: 0, shi: 6, slo: 7};
    tbl[1] = '{rf_hi: 0, amt: 60, ord: "HHHHHH", owed: 0, flt: 0, shi: 0, slo: 7};
    tbl[2] = '{rf_hi: 0, amt: 20, ord: "LLLL",   owed: 0, flt: 0, shi: 0, slo: 3};
    tbl[3] = '{rf_hi: 1, amt: 13, ord: "H",      owed: 3, flt: 1, shi: 7, slo: 3};

    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_owed", owed, 0);
    chk("rst_fault", fault, 0);
    chk("rst_eject", {eject_hi, eject_lo}, 0);
    chk("rst_stock_hi", int'(dut.stock_hi_q), 8);
    chk("rst_stock_lo", int'(dut.stock_lo_q), 8);

    coin_ack = 1'b1; tick(); coin_ack = 1'b0; tick();
    chk("idle_ack_owed", owed, 0);
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_stock", int'(dut.stock_hi_q), 8);

    foreach (tbl[i]) begin
      if (tbl[i].rf_hi) begin refill_hi = 1'b1; tick(); refill_hi = 1'b0; end
      pay(tbl[i].amt, ord, bad_w, done);
      chk($sformatf("row%0d_done", i), done, 1);
      chk_s($sformatf("row%0d_order", i), ord, tbl[i].ord);
      chk($sformatf("row%0d_pulse_w", i), bad_w, 0);
      chk($sformatf("row%0d_owed", i), owed, tbl[i].owed);
      chk($sformatf("row%0d_fault", i), fault, tbl[i].flt);
      chk($sformatf("row%0d_stock_hi", i), int'(dut.stock_hi_q), tbl[i].shi);
      chk($sformatf("row%0d_stock_lo", i), int'(dut.stock_lo_q), tbl[i].slo);
      if (!tbl[i].flt) chk($sformatf("row%0d_busy", i), busy, 0);
    end

    // Remainder 3 is unpayable: hold in FAULT, retry faults again
    n = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (eject_hi | eject_lo) n++; end
    chk("fault_no_eject", n, 0);
    clear_fault = 1'b1; tick(); clear_fault = 1'b0;
    chk("clear_leaves_fault", fault, 0);
    tick();
    chk("clear_refaults", fault, 1);
    chk("clear_owed", owed, 3);
    change_in = 6'd2; tick(); change_in = '0;
    chk("fault_accum_owed", owed, 5);
    chk("fault_accum_stays", fault, 1);

    // Latency and ack timeout
    do_reset();
    change_in = 6'd10; tick(); change_in = '0;
    chk("lat_k_busy", busy, 0);
    chk("lat_k_owed", owed, 10);
    tick();
    chk("lat_k1_busy", busy, 1);
    chk("lat_k1_eject", eject_hi, 0);
    tick();
    chk("lat_k2_eject", eject_hi, 1);
    n = 1;
    for (int c = 0; c < 20 && eject_hi; c++) begin tick(); if (eject_hi) n++; end
    chk("pulse_width", n, PULSE);
    n = 0;
    for (int c = 0; c < 300; c++) begin tick(); n++; if (fault) break; end
    chk("timeout_cycles", n, TMO);
    chk("timeout_owed", owed, 10);
    chk("timeout_stock_hi", int'(dut.stock_hi_q), 8);

    // Change arriving mid-wait is accumulated
    do_reset();
    change_in = 6'd10; tick(); change_in = '0;
    wait_fall(saw_hi, ok);
    chk("accum_first_hi", {ok, saw_hi}, 2'b11);
    change_in = 6'd5; tick(); change_in = '0;
    chk("accum_owed", owed, 15);
    drain(0, ord, bad_w, done);
    chk_s("accum_order", {"H", ord}, "HL");
    chk("accum_final_owed", owed, 0);

    // Saturation
    do_reset();
    change_in = 6'd10; tick();
    chk("sat_owed10", owed, 10);
    change_in = 6'd60; tick();
    chk("sat_owed63", owed, 63);
    change_in = 6'd1; tick(); change_in = '0;
    chk("sat_hold63", owed, 63);

    // Refill and ack in the same cycle: refill wins
    do_reset();
    change_in = 6'd10; tick(); change_in = '0;
    wait_fall(saw_hi, ok);
    coin_ack = 1'b1; refill_hi = 1'b1; tick(); coin_ack = 1'b0; refill_hi = 1'b0;
    chk("refill_ack_stock", int'(dut.stock_hi_q), 8);
    chk("refill_ack_owed", owed, 0);

    // Reset during second cycle of an eject pulse
    do_reset();
    pay(15, ord, bad_w, done);
    chk_s("pre_rst_order", ord, "HL");
    chk("pre_rst_stock_lo", int'(dut.stock_lo_q), 7);
    change_in = 6'd10; tick(); change_in = '0;
    for (int c = 0; c < 10 && !eject_hi; c++) tick();
    tick();
    chk("mid_pulse_2nd", eject_hi, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_eject", eject_hi, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_owed", owed, 0);
    chk("rst_mid_stock_hi", int'(dut.stock_hi_q), 8);
    chk("rst_mid_stock_lo", int'(dut.stock_lo_q), 8);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
